// File: rtl/seg_scan_if.sv
// Display-scan bus: scan control and digit data from the host side,
// decoder code, anode enables, decimal point and frame pulse from the controller.
interface seg_scan_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic [4*DIGITS-1:0]   digits_in;
    logic [DIGITS-1:0]     dot_in;
    logic                  lz_en;
    logic [3:0]            num_out;
    logic [DIGITS-1:0]     an;
    logic                  dp;
    logic                  frame_tick;

    modport master (
        output en,
        output digits_in,
        output dot_in,
        output lz_en,
        input  num_out,
        input  an,
        input  dp,
        input  frame_tick
    );

    modport slave (
        input  en,
        input  digits_in,
        input  dot_in,
        input  lz_en,
        output num_out,
        output an,
        output dp,
        output frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller for a common-anode display.
// Each frame snapshots the digit word, then walks digit 0..DIGITS-1, giving every
// digit a blanking gap (all anodes off) followed by its lit period. Digits holding
// a non-BCD code, and leading zeros when suppression is on, stay dark.
module seg_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan_if.slave   bus
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(DIGITS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [1:0]          state;
    logic [IW-1:0]       idx;
    logic [CW-1:0]       cnt;
    logic [4*DIGITS-1:0] snap_digits;
    logic [DIGITS-1:0]   snap_dots;
    logic                snap_lz;

    logic [3:0]          num_q;
    logic [DIGITS-1:0]   an_q;
    logic                dp_q;
    logic                tick_q;

    logic [1:0]          nxt_state;
    logic [IW-1:0]       nxt_idx;
    logic [CW-1:0]       nxt_cnt;
    logic [4*DIGITS-1:0] nxt_digits;
    logic [DIGITS-1:0]   nxt_dots;
    logic                nxt_lz;
    logic                nxt_tick;

    logic [DIGITS-1:0]   vis;
    logic                zero_run;
    logic [3:0]          cur_digit;
    logic [3:0]          cur_num;
    logic                cur_vis;

    logic [3:0]          num_n;
    logic [DIGITS-1:0]   an_n;
    logic                dp_n;

    // Next-state logic: slot sequencing, digit walk and frame-boundary snapshot.
    always_comb begin
        nxt_state  = state;
        nxt_idx    = idx;
        nxt_cnt    = cnt;
        nxt_digits = snap_digits;
        nxt_dots   = snap_dots;
        nxt_lz     = snap_lz;
        nxt_tick   = 1'b0;
        if (!bus.en) begin
            nxt_state = ST_IDLE;
            nxt_idx   = '0;
            nxt_cnt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    nxt_state  = ST_BLANK;
                    nxt_idx    = '0;
                    nxt_cnt    = '0;
                    nxt_digits = bus.digits_in;
                    nxt_dots   = bus.dot_in;
                    nxt_lz     = bus.lz_en;
                end
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        nxt_cnt   = '0;
                        nxt_state = ST_SHOW;
                    end else begin
                        nxt_cnt = cnt + CW'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        nxt_cnt   = '0;
                        nxt_state = ST_BLANK;
                        if (idx == IDX_LAST) begin
                            nxt_idx    = '0;
                            nxt_tick   = 1'b1;
                            nxt_digits = bus.digits_in;
                            nxt_dots   = bus.dot_in;
                            nxt_lz     = bus.lz_en;
                        end else begin
                            nxt_idx = idx + IW'(1);
                        end
                    end else begin
                        nxt_cnt = cnt + CW'(1);
                    end
                end
                default: begin
                    nxt_state = ST_IDLE;
                    nxt_idx   = '0;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    // Per-digit visibility on the snapshot that will be active after this edge:
    // dark if non-BCD, or if it is a leading zero (not digit 0) while suppression is on.
    always_comb begin
        vis      = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (nxt_digits[4*k +: 4] == 4'd0);
            vis[k]   = (nxt_digits[4*k +: 4] <= 4'd9) && !(nxt_lz && (k != 0) && zero_run);
        end
    end

    // Decoder code for the upcoming slot, clamped so the decoder only ever sees 0..9.
    always_comb begin
        cur_digit = nxt_digits[{nxt_idx, 2'b00} +: 4];
        cur_num   = (cur_digit > 4'd9) ? 4'd0 : cur_digit;
        cur_vis   = vis[nxt_idx];
    end

    // Output values matching the state entered on this edge; code holds while idle.
    always_comb begin
        num_n = num_q;
        an_n  = '1;
        dp_n  = 1'b1;
        case (nxt_state)
            ST_BLANK: begin
                num_n = cur_num;
            end
            ST_SHOW: begin
                num_n = cur_num;
                if (cur_vis) begin
                    an_n[nxt_idx] = 1'b0;
                    dp_n          = ~nxt_dots[nxt_idx];
                end
            end
            default: begin
                num_n = num_q;
            end
        endcase
    end

    // State, snapshot and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            cnt         <= '0;
            snap_digits <= '0;
            snap_dots   <= '0;
            snap_lz     <= 1'b0;
            num_q       <= 4'd0;
            an_q        <= '1;
            dp_q        <= 1'b1;
            tick_q      <= 1'b0;
        end else begin
            state       <= nxt_state;
            idx         <= nxt_idx;
            cnt         <= nxt_cnt;
            snap_digits <= nxt_digits;
            snap_dots   <= nxt_dots;
            snap_lz     <= nxt_lz;
            num_q       <= num_n;
            an_q        <= an_n;
            dp_q        <= dp_n;
            tick_q      <= nxt_tick;
        end
    end

    assign bus.num_out    = num_q;
    assign bus.an         = an_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = tick_q;

endmodule
